// File: rtl/led_counter_ctrl.sv
// led_counter_ctrl: debounces six front-panel buttons and drives the LED counter's speed, direction, run and invert controls,
// either directly from presses (MANUAL) or from a demo sweep of the speed select (AUTO).
module led_counter_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STEP_CYCLES     = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       btn_dir,
    input  logic       btn_pause,
    input  logic       btn_inv,
    input  logic       btn_mode,
    output logic [2:0] sw,
    output logic       ud,
    output logic       pause,
    output logic       inv,
    output logic       auto_mode
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(STEP_CYCLES);
    typedef enum logic [1:0] {MANUAL, RAMP_UP, RAMP_DN} state_t;
    state_t state, state_nx;
    logic [5:0] raw, s1, s2, lvl, lvl_q, press;
    logic [2:0] sw_nx;
    logic ud_nx, pause_nx, inv_nx, step;
    logic [TW-1:0] timer, timer_nx;
    assign raw   = {btn_mode, btn_inv, btn_pause, btn_dir, btn_dn, btn_up};
    assign press = lvl & ~lvl_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            lvl_q <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_q <= lvl;
        end
    end
    // A level is accepted only after DEBOUNCE_CYCLES consecutive synced samples disagree with it.
    for (genvar i = 0; i < 6; i++) begin : g_db
        logic [DW-1:0] cnt;
        logic l;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
                l   <= 1'b0;
            end else if (s2[i] == l) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= '0;
                l   <= s2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign lvl[i] = l;
    end
    always_comb begin
        state_nx = state;
        sw_nx    = sw;
        ud_nx    = ud;
        timer_nx = '0;
        pause_nx = pause ^ press[3];
        inv_nx   = inv ^ press[4];
        step     = (state != MANUAL) && pause && (timer == TW'(STEP_CYCLES - 1)) && !press[5];
        if (state == MANUAL) begin
            state_nx = press[5] ? RAMP_UP : MANUAL;
            if (press[0] && !press[1] && sw != 3'd7) sw_nx = sw + 3'd1;
            if (press[1] && !press[0] && sw != 3'd0) sw_nx = sw - 3'd1;
            ud_nx = ud ^ press[2];
        end else if (press[5]) begin
            state_nx = MANUAL;
        end else begin
            timer_nx = pause ? (step ? '0 : timer + 1'b1) : timer;
            if (step && state == RAMP_UP) begin
                sw_nx    = (sw == 3'd7) ? sw : sw + 3'd1;
                ud_nx    = (sw == 3'd7) ? ~ud : ud;
                state_nx = (sw == 3'd7) ? RAMP_DN : RAMP_UP;
            end
            if (step && state == RAMP_DN) begin
                sw_nx    = (sw == 3'd0) ? sw : sw - 3'd1;
                ud_nx    = (sw == 3'd0) ? ~ud : ud;
                state_nx = (sw == 3'd0) ? RAMP_UP : RAMP_DN;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= MANUAL;
            timer     <= '0;
            sw        <= 3'd0;
            ud        <= 1'b1;
            pause     <= 1'b1;
            inv       <= 1'b0;
            auto_mode <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            sw        <= sw_nx;
            ud        <= ud_nx;
            pause     <= pause_nx;
            inv       <= inv_nx;
            auto_mode <= state_nx != MANUAL;
        end
    end
endmodule
